// File: rtl/fetch_pc_if.sv
// Instruction-bus interface between the fetch PC generator (master) and the instruction memory (slave).
// ireq_valid/ireq_addr are held stable from assertion until the cycle iresp_data_ok is high; that cycle completes the single outstanding request.
interface fetch_pc_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/fetch_pc.sv
// Fetch PC generator: single-outstanding instruction-bus requester with a one-entry output buffer.
// Optional macro FETCH_MISALIGN_EXC_EN turns misaligned redirect targets into buffered exception markers.
module fetch_pc #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redir_valid,
    input  logic [63:0]       redir_pc,
    fetch_pc_if.master        ibus,
    output logic              f_valid,
    output logic [63:0]       f_pc,
    output logic [31:0]       f_instr,
    output logic [2:0]        dbg_state
`ifdef FETCH_MISALIGN_EXC_EN
    ,
    output logic              f_misalign
`endif
);

    typedef enum logic [2:0] {
        START   = 3'd0,
        FETCH   = 3'd1,
        HOLD    = 3'd2,
        DISCARD = 3'd3
`ifdef FETCH_MISALIGN_EXC_EN
        ,
        EXC     = 3'd4
`endif
    } state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] pend_pc, pend_n;
    logic        fv_n;
    logic [63:0] fpc_n;
    logic [31:0] finstr_n;
    logic        acc;
    logic [63:0] tgt;
    logic        go_redir;
    logic [63:0] go_tgt;
`ifdef FETCH_MISALIGN_EXC_EN
    logic        fmis_n;
`endif

    assign acc = redir_valid & ~stall;

`ifdef FETCH_MISALIGN_EXC_EN
    assign tgt = redir_pc;
`else
    // Low target bits are meaningless without the exception path; force word alignment.
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^redir_pc[1:0];
    assign tgt = {redir_pc[63:2], 2'b00};
`endif

    assign ibus.ireq_valid = (state == FETCH) || (state == DISCARD);
    assign ibus.ireq_addr  = pc;
    assign dbg_state       = state;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        pend_n   = pend_pc;
        fv_n     = f_valid;
        fpc_n    = f_pc;
        finstr_n = f_instr;
        go_redir = 1'b0;
        go_tgt   = tgt;
`ifdef FETCH_MISALIGN_EXC_EN
        fmis_n   = f_misalign;
`endif
        case (state)
            START: state_n = FETCH;
            FETCH: begin
                if (ibus.iresp_data_ok) begin
                    if (acc) begin
                        go_redir = 1'b1;
                    end else begin
                        fv_n     = 1'b1;
                        fpc_n    = pc;
                        finstr_n = ibus.iresp_data;
                        pc_n     = pc + 64'd4;
                        state_n  = HOLD;
                    end
                end else if (acc) begin
                    pend_n  = tgt;
                    state_n = DISCARD;
                end
            end
            HOLD: begin
                if (acc) begin
                    go_redir = 1'b1;
                end else if (!stall) begin
                    fv_n    = 1'b0;
                    state_n = FETCH;
                end
            end
            DISCARD: begin
                // The stale response must drain before the bus can carry the new address.
                if (ibus.iresp_data_ok) begin
                    go_redir = 1'b1;
                    go_tgt   = acc ? tgt : pend_pc;
                end else if (acc) begin
                    pend_n = tgt;
                end
            end
`ifdef FETCH_MISALIGN_EXC_EN
            EXC: begin
                if (acc) begin
                    go_redir = 1'b1;
                end else if (!stall) begin
                    fv_n   = 1'b0;
                    fmis_n = 1'b0;
                end
            end
`endif
            default: state_n = START;
        endcase

        if (go_redir) begin
            fv_n = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
            fmis_n = 1'b0;
            if (go_tgt[1:0] != 2'b00) begin
                fv_n     = 1'b1;
                fpc_n    = go_tgt;
                finstr_n = 32'd0;
                fmis_n   = 1'b1;
                state_n  = EXC;
            end else
`endif
            begin
                pc_n    = go_tgt;
                state_n = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= START;
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
            f_valid <= 1'b0;
            f_pc    <= 64'd0;
            f_instr <= 32'd0;
`ifdef FETCH_MISALIGN_EXC_EN
            f_misalign <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pend_pc <= pend_n;
            f_valid <= fv_n;
            f_pc    <= fpc_n;
            f_instr <= finstr_n;
`ifdef FETCH_MISALIGN_EXC_EN
            f_misalign <= fmis_n;
`endif
        end
    end

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Fetch-side PC generator and instruction-bus requester.
- Consumes the redirect (PCSel / target address) that the decode-stage jump logic produces.
- Drives single-outstanding requests on the instruction bus and holds one fetched instruction in an output buffer for the F/D pipeline register.
- Handles redirects that arrive while a bus request is in flight by draining and discarding the stale response.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC fetched first after reset release.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-low reset.
stall  input  1  downstream (F/D register) not accepting this cycle.
redir_valid  input  1  decode requests a PC redirect.
redir_pc  input  64  redirect target.
ireq_valid  output  1  instruction-bus request valid.
ireq_addr  output  64  request address.
iresp_data_ok  input  1  response for the outstanding request is valid this cycle.
iresp_data  input  32  instruction word.
f_valid  output  1  output buffer holds an instruction.
f_pc  output  64  PC of the buffered instruction.
f_instr  output  32  buffered instruction.
f_misalign  output  1  buffered entry is a misaligned-target marker. Present only with the optional feature.

Behaviour:
- States: START, FETCH, HOLD, DISCARD. Add EXC with the optional feature.
- Registers:
  - pc: current fetch address.
  - pend_pc: pending redirect target.
  - output buffer: f_valid, f_pc, f_instr.
- Reset (async, any cycle, including mid-request):
  - state = START; pc = RESET_PC; f_valid = 0; f_pc = 0; f_instr = 0; f_misalign = 0.
  - ireq_valid = 0; ireq_addr = RESET_PC.
  - An in-flight bus transaction is abandoned.
- ireq_valid = 1 in FETCH and DISCARD only (decoded from registered state).
- ireq_addr = pc.
- Address and valid stay stable from assertion until the data_ok cycle.
- Accepted redirect: acc = redir_valid & ~stall. Redirects while stall = 1 are ignored; decode holds them until it advances.
- START: next cycle -> FETCH.
- FETCH (buffer empty):
  - data_ok & ~acc: buffer <= {1, pc, iresp_data}; pc <= pc + 4; -> HOLD.
  - data_ok & acc: data dropped; pc <= redir_pc; stay FETCH. The new address is presented next cycle.
  - ~data_ok & acc: pend_pc <= redir_pc; -> DISCARD. ireq_addr stays at the old pc.
- HOLD (ireq_valid = 0):
  - acc: f_valid <= 0 (squash); pc <= redir_pc; -> FETCH.
  - ~stall & ~redir_valid: f_valid <= 0 (consumed); -> FETCH.
  - stall: f_* held stable.
- DISCARD:
  - Keeps requesting the old pc.
  - A further acc overwrites pend_pc (latest wins).
  - On data_ok: data dropped; pc <= (acc ? redir_pc : pend_pc); -> FETCH.
- f_valid never goes high in FETCH or DISCARD.
- Throughput: at most one instruction per 2 cycles plus bus latency.
- Arithmetic: pc + 4 is 64-bit, wraps modulo 2^64 with no flag.
- Without the optional feature, redir_pc[1:0] is forced to 0.

Optional Feature:
- Macro: FETCH_MISALIGN_EXC_EN.
- Defined:
  - An accepted redirect with redir_pc[1:0] != 0 issues no bus request.
  - Buffer <= {f_valid = 1, f_pc = redir_pc, f_instr = 0, f_misalign = 1}; -> EXC.
  - If taken in DISCARD, this happens after the drained data_ok.
  - EXC behaves as HOLD while buffered. After consumption, f_valid = 0 and ireq_valid = 0 until the next accepted redirect (-> FETCH, or EXC again).
  - f_misalign = 0 for normal entries.
- Undefined: port f_misalign and state EXC are absent; redir_pc[1:0] forced to 0.

Test Plan:
1. Reset release, data_ok 2 cycles after ireq_valid with 32'h00000013 -> ireq_addr = 0x80000000 held until data_ok; then f_valid = 1, f_pc = 0x80000000, f_instr = 0x00000013; next request at 0x80000004.
2. HOLD with stall = 1 for 3 cycles, redir_valid = 1 throughout -> f_valid/f_pc/f_instr unchanged, ireq_valid = 0, no redirect taken; stall drops -> redirect taken, f_valid = 0 next cycle.
3. HOLD, acc to 0x80000100 -> next cycle f_valid = 0, ireq_valid = 1, ireq_addr = 0x80000100.
4. FETCH at 0x80000008, acc to 0x80000200 with no data_ok, data_ok 3 cycles later -> ireq_addr stays 0x80000008 through data_ok, f_valid stays 0, then ireq_addr = 0x80000200.
5. DISCARD with acc to 0x80000300 then 0x80000400 before data_ok -> next fetch at 0x80000400. Also assert reset mid-DISCARD -> ireq_valid = 0 immediately and fetch restarts at RESET_PC.
6. FETCH_MISALIGN_EXC_EN defined, acc to 0x80000102 -> f_valid = 1, f_misalign = 1, f_instr = 0, f_pc = 0x80000102, no ireq; after consume, ireq_valid stays 0 until acc to 0x80000400.
